// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared function codes, FSM states and command layout for the ALU command scheduler
package alu_sched_pkg;
   localparam logic [2:0] FN_ADD = 3'd0;
   localparam logic [2:0] FN_SUB = 3'd1;
   localparam logic [2:0] FN_MUL = 3'd2;
   localparam logic [2:0] FN_DIV = 3'd3;
   localparam logic [2:0] FN_AND = 3'd4;
   localparam logic [2:0] FN_OR  = 3'd5;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [7:0] op1;
      logic [7:0] op2;
      logic [2:0] fn;
   } cmd_t;

   // Commands answered locally with an error instead of being sent to the ALU
   function automatic logic reject(input logic [2:0] fn, input logic op2_zero);
      return fn > FN_OR || (fn == FN_DIV && op2_zero);
   endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO with occupancy count
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 19
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rp];
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/alu_cmd_sched.sv
// alu_cmd_sched: buffers ALU commands, issues them one at a time, and returns
// each result (or a local rejection) on a valid/ready response port
module alu_cmd_sched
   import alu_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int OP_W = 8,
   parameter int RES_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [OP_W-1:0]           cmd_op1,
   input  logic [OP_W-1:0]           cmd_op2,
   input  logic [2:0]                cmd_fn,
   output logic                      alu_en,
   output logic [OP_W-1:0]           alu_op1,
   output logic [OP_W-1:0]           alu_op2,
   output logic [2:0]                alu_fn,
   input  logic [RES_W-1:0]          alu_result,
   input  logic                      alu_valid,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [RES_W-1:0]          rsp_data,
   output logic                      rsp_err,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic [7:0]                err_cnt
);
   localparam int W = 2 * OP_W + 3;
   state_t state, state_nx;
   logic [W-1:0] head;
   logic [OP_W-1:0] h_op1, h_op2;
   logic [2:0] h_fn;
   logic full, empty, pop, rej;
   assign {h_op1, h_op2, h_fn} = head;
   assign rej = reject(h_fn, h_op2 == '0);
   // Ready comes from the registered count only, so a same-cycle pop never reopens a full FIFO
   assign cmd_ready = !full && !rst;
   assign pop = state == IDLE && !empty;

   cmd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid && cmd_ready),
      .pop   (pop),
      .din   ({cmd_op1, cmd_op2, cmd_fn}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  state_nx = empty ? IDLE : (rej ? RESP : ISSUE);
         ISSUE: state_nx = WAIT;
         WAIT:  state_nx = RESP;
         RESP:  state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      alu_en = state == ISSUE;
      rsp_valid = state == RESP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_op1 <= '0;
         alu_op2 <= '0;
         alu_fn <= '0;
         rsp_data <= '0;
         rsp_err <= 1'b0;
         err_cnt <= '0;
      end else begin
         if (pop && !rej) begin
            alu_op1 <= h_op1;
            alu_op2 <= h_op2;
            alu_fn <= h_fn;
         end
         if (pop && rej) begin
            rsp_data <= '0;
            rsp_err <= 1'b1;
         end
         // A missing alu_valid in WAIT means the ALU dropped the command
         if (state == WAIT) begin
            rsp_data <= alu_valid ? alu_result : '0;
            rsp_err <= !alu_valid;
         end
         if (rsp_valid && rsp_ready && rsp_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end
endmodule

// File: doc/alu_cmd_sched.md
# alu_cmd_sched

Command scheduler that sits directly upstream of the 8-bit registered ALU. It buffers operand/function commands from a valid/ready producer in a small FIFO and issues them to the ALU one at a time as single-cycle `enable` pulses. It captures the 16-bit ALU result with an error flag and presents it on a valid/ready response port. Illegal functions and divide-by-zero are rejected locally and never reach the ALU.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2
- OP_W, 8, operand width
- RES_W, 16, result width (2*OP_W)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  producer command valid
- cmd_ready  out  1  FIFO can accept (count < DEPTH)
- cmd_op1  in  OP_W  operand 1
- cmd_op2  in  OP_W  operand 2
- cmd_fn  in  3  function: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or
- alu_en  out  1  ALU enable, one-cycle pulse per issued command
- alu_op1  out  OP_W  operand 1 to ALU (registered)
- alu_op2  out  OP_W  operand 2 to ALU (registered)
- alu_fn  out  3  function to ALU (registered)
- alu_result  in  RES_W  ALU registered result
- alu_valid  in  1  ALU result valid
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer ready
- rsp_data  out  RES_W  result; 0 on error
- rsp_err  out  1  1 = illegal fn, div by zero, or ALU handshake failure
- fifo_count  out  $clog2(DEPTH)+1  entries held
- err_cnt  out  8  saturating count of responses with rsp_err=1

## Operation
- Reset values: cmd_ready 0 while rst high (1 after release), alu_en 0, alu_op1/op2/fn 0, rsp_valid 0, rsp_data 0, rsp_err 0, fifo_count 0, err_cnt 0, state IDLE.
- FIFO push on cmd_valid && cmd_ready. cmd_ready derives only from registered count, so a pop in the same cycle does not reopen a full FIFO. Simultaneous push and pop when not full: count unchanged. Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if count>0, pop head. If fn ∈ {6,7} or (fn==3 && op2==0), load rsp_data=0, rsp_err=1 and go to RESP. Otherwise load alu_op1/op2/fn and go to ISSUE.
  - ISSUE: alu_en=1 for this cycle only, then go to WAIT.
  - WAIT: one cycle. If alu_valid, rsp_data=alu_result and rsp_err=0. Otherwise rsp_data=0 and rsp_err=1. Go to RESP.
  - RESP: rsp_valid=1, and rsp_data/rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE. err_cnt increments when rsp_err=1 and saturates at 255.
- alu_op1/op2/fn hold their last issued values outside ISSUE.
- At most one command is in flight. A command is issued only when the response slot is empty.
- Sub results are the ALU's 16-bit wrap value, passed through unmodified. No width conversion happens in this block.
- Reset mid-operation: FIFO emptied, in-flight command and pending response discarded. The first post-reset cycle is IDLE.

## Timing
- Command handshake at edge E0 → IDLE pops at E1 → alu_en high in cycle E1–E2 → ALU registers at E2 → WAIT captures at E3 → rsp_valid high from E3.
- Legal command: 3 cycles from accept to rsp_valid (FIFO otherwise empty, rsp_ready high).
- Rejected command: 1 cycle from accept to rsp_valid.
- With rsp_ready held high, back-to-back throughput is one legal command per 4 cycles (IDLE, ISSUE, WAIT, RESP).
- rsp_ready low stalls the FSM in RESP. The FIFO continues to accept until full.

## Structure
- Package alu_sched_pkg holds:
  - function constants FN_ADD=0, FN_SUB=1, FN_MUL=2, FN_DIV=3, FN_AND=4, FN_OR=5
  - the FSM state enum {IDLE, ISSUE, WAIT, RESP}
  - a command struct {op1, op2, fn}
- Sub-module cmd_fifo: synchronous FIFO parameterised by DEPTH and width. It provides push/pop, full/empty, and count. The top level contains the FSM, response register, and err_cnt.

## Test plan
- Single add: op1=200, op2=100, fn=0 → one alu_en pulse 1 cycle after accept. rsp_valid 3 cycles after accept, rsp_data=300, rsp_err=0.
- Divide by zero: op1=9, op2=0, fn=3 → alu_en never asserts. rsp_valid 1 cycle after accept, rsp_data=0, rsp_err=1, err_cnt=1.
- Fill and backpressure: rsp_ready=0, push 5 muls (15*15) → first accepted and issued; cmd_ready drops at fifo_count=4. Raise rsp_ready → 5 responses of 225 in order.
- Illegal fn=7, then legal sub 5−7 → first response err=1 data=0. Second response data=16'hFFFE, err=0.
- ALU handshake failure: force alu_valid=0 in WAIT → rsp_err=1, rsp_data=0.
- Reset mid-flight: assert rst during WAIT with 3 entries queued → next cycle fifo_count=0, rsp_valid=0, alu_en=0. No stale response appears after release.
